// File: rtl/conv_pool_pkg.sv
// rtl/conv_pool_pkg.sv - shared sizes, FSM states and row type for the conv->pool output sequencer
package conv_pool_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int INPUT_SIZE   = 6;
    localparam int FEATURE_NUM  = 4;
    localparam int FEATURE_ROWS = 6;
    localparam int ROW_BITS     = DATA_WIDTH * INPUT_SIZE;
    localparam int IDX_W        = $clog2(FEATURE_NUM);
    localparam int ROW_W        = $clog2(FEATURE_ROWS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } seq_state_t;

    typedef logic [ROW_BITS-1:0] row_t;

    // Lane 0 sits in the MSBs; a set sign bit (including -0.0) clamps the lane to +0.0.
    function automatic row_t relu_row(input row_t i_row);
        row_t r;
        r = i_row;
        for (int i = 0; i < INPUT_SIZE; i++) begin
            if (i_row[ROW_BITS-1-i*DATA_WIDTH]) begin
                r[ROW_BITS-1-i*DATA_WIDTH -: DATA_WIDTH] = '0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_pool_row_fifo.sv
// rtl/conv_pool_row_fifo.sv - synchronous row buffer between the conv array and the sequencer FSM
module conv_pool_row_fifo
    import conv_pool_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [ROW_BITS-1:0] i_data,
    input  logic             i_pop,
    output logic [ROW_BITS-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    row_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && (r_count != CNT_W'(DEPTH));
    assign w_pop  = i_pop && (r_count != '0);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/conv_pool_output_sequencer.sv
// rtl/conv_pool_output_sequencer.sv - buffers conv rows and replays them as spaced kernel_calc_fin strobes
// Optional CONV_POOL_RELU_EN: rectify each lane as it is registered into data_out.
module conv_pool_output_sequencer
    import conv_pool_pkg::*;
#(
    parameter int  FIFO_DEPTH = 4,
    parameter int  MIN_GAP    = 4,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1,
    localparam int GAP_W      = $clog2(MIN_GAP)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_conv_valid,
    output logic                o_conv_ready,
    input  logic [ROW_BITS-1:0] i_conv_data,
    output logic [ROW_BITS-1:0] o_data_out,
    output logic                o_kernel_calc_fin,
    output logic [IDX_W-1:0]    o_feature_idx,
    output logic [ROW_W-1:0]    o_feature_row,
    output logic                o_frame_done,
    output logic                o_busy
);

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [IDX_W-1:0] r_cnt_idx;
    logic [ROW_W-1:0] r_cnt_row;

    row_t             r_data_out;
    logic [IDX_W-1:0] r_feature_idx;
    logic [ROW_W-1:0] r_feature_row;
    logic             r_fin;
    logic             r_frame_done;
    logic             r_conv_ready;

    logic             w_push;
    logic             w_pop;
    logic             w_issue;
    logic             w_last;
    row_t             w_fifo_data;
    row_t             w_row_in;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_next;

    assign w_push = i_conv_valid && r_conv_ready && !w_full;

    conv_pool_row_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_row_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (i_conv_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Ready is registered from next-cycle occupancy so it never lags a pop or admits a push into a full buffer.
    assign w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

`ifdef CONV_POOL_RELU_EN
    assign w_row_in = relu_row(w_fifo_data);
`else
    assign w_row_in = w_fifo_data;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                w_next_state = GAP;
            end
            GAP: begin
                if (r_gap_cnt == '0) begin
                    w_next_state = w_empty ? IDLE : ISSUE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        w_pop   = (w_next_state == ISSUE) && (r_state != ISSUE);
        w_issue = (r_state == ISSUE);
        w_last  = w_issue
                  && (r_cnt_idx == IDX_W'(FEATURE_NUM - 1))
                  && (r_cnt_row == ROW_W'(FEATURE_ROWS - 1));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_gap_cnt     <= '0;
            r_cnt_idx     <= '0;
            r_cnt_row     <= '0;
            r_data_out    <= '0;
            r_feature_idx <= '0;
            r_feature_row <= '0;
            r_fin         <= 1'b0;
            r_frame_done  <= 1'b0;
            r_conv_ready  <= 1'b0;
        end else begin
            r_conv_ready <= (w_count_next != CNT_W'(FIFO_DEPTH));
            r_fin        <= w_issue;
            r_frame_done <= w_last;

            if (w_pop) begin
                r_data_out    <= w_row_in;
                r_feature_idx <= r_cnt_idx;
                r_feature_row <= r_cnt_row;
            end

            if (w_issue) begin
                r_gap_cnt <= GAP_W'(MIN_GAP - 1);
                if (r_cnt_row == ROW_W'(FEATURE_ROWS - 1)) begin
                    r_cnt_row <= '0;
                    r_cnt_idx <= (r_cnt_idx == IDX_W'(FEATURE_NUM - 1)) ? '0 : r_cnt_idx + IDX_W'(1);
                end else begin
                    r_cnt_row <= r_cnt_row + ROW_W'(1);
                end
            end else if ((r_state == GAP) && (r_gap_cnt != '0)) begin
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end
        end
    end

    assign o_conv_ready      = r_conv_ready;
    assign o_data_out        = r_data_out;
    assign o_kernel_calc_fin = r_fin;
    assign o_feature_idx     = r_feature_idx;
    assign o_feature_row     = r_feature_row;
    assign o_frame_done      = r_frame_done;
    assign o_busy            = !w_empty || (r_state != IDLE);

endmodule

// File: tb/tb_conv_pool_output_sequencer.sv
// tb/tb_conv_pool_output_sequencer.sv - directed table-driven bench for conv_pool_output_sequencer
module tb_conv_pool_output_sequencer;

    logic         clk;
    logic         rst;
    logic         conv_valid;
    logic         conv_ready;
    logic [191:0] conv_data;
    logic [191:0] data_out;
    logic         fin;
    logic [1:0]   feature_idx;
    logic [2:0]   feature_row;
    logic         frame_done;
    logic         busy;

    conv_pool_output_sequencer dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_conv_valid      (conv_valid),
        .o_conv_ready      (conv_ready),
        .i_conv_data       (conv_data),
        .o_data_out        (data_out),
        .o_kernel_calc_fin (fin),
        .o_feature_idx     (feature_idx),
        .o_feature_row     (feature_row),
        .o_frame_done      (frame_done),
        .o_busy            (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int           cyc;
        logic [191:0] data;
        logic [1:0]   idx;
        logic [2:0]   row;
        logic         fd;
    } strobe_t;

    typedef struct {
        logic [1:0] idx;
        logic [2:0] row;
        logic       fd;
    } tag_vec_t;

    typedef struct {
        logic [31:0] lane_in;
        logic [31:0] lane_exp;
    } lane_vec_t;

    strobe_t      sq[$];
    logic [191:0] exp_q[$];
    tag_vec_t     tag_tab[25];
    lane_vec_t    lane_tab[6];
    logic [31:0]  t2_lanes[6];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fin === 1'b1) begin
            sq.push_back('{cyc: cyc, data: data_out, idx: feature_idx, row: feature_row, fd: frame_done});
        end
    end

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [191:0] mk_row(input int n);
        logic [191:0] r;
        logic [7:0]   nb;
        nb = 8'(n);
        for (int l = 0; l < 6; l++) begin
            r[191-32*l -: 32] = {8'h01, nb, 8'h00, 8'(l)};
        end
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        conv_valid = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
        sq.delete();
        exp_q.delete();
    endtask

    task automatic push_rows(input int n, input int base, output int acc_before_stall, output bit stalled);
        int sent = 0;
        int guard = 0;
        acc_before_stall = 0;
        stalled = 1'b0;
        while (sent < n && guard < 500) begin
            conv_valid = 1'b1;
            conv_data  = mk_row(base + sent);
            if (conv_ready) begin
                exp_q.push_back(mk_row(base + sent));
                sent++;
                if (!stalled) acc_before_stall++;
            end else begin
                stalled = 1'b1;
            end
            step();
            guard++;
        end
        conv_valid = 1'b0;
        check("push_rows_done", 192'(sent), 192'(n));
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int k = 0;
        while (sq.size() < n && k < budget) begin
            step();
            k++;
        end
        check("strobe_count_in_budget", 192'(sq.size() >= n), 192'(1));
    endtask

    initial begin
        int           acc;
        bit           stalled;
        bit           held;
        logic [191:0] t2_row;
        logic [191:0] relu_row_in;
        logic [191:0] relu_exp;

        for (int n = 0; n < 25; n++) begin
            tag_tab[n].idx = 2'((n / 6) % 4);
            tag_tab[n].row = 3'(n % 6);
            tag_tab[n].fd  = (n == 23);
        end
        t2_lanes = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
`ifdef CONV_POOL_RELU_EN
        lane_tab = '{'{32'hBF800000, 32'h00000000}, '{32'h80000000, 32'h00000000},
                     '{32'h3F800000, 32'h3F800000}, '{32'h7F800000, 32'h7F800000},
                     '{32'hFFC00000, 32'h00000000}, '{32'h00000001, 32'h00000001}};
`else
        lane_tab = '{'{32'hBF800000, 32'hBF800000}, '{32'h80000000, 32'h80000000},
                     '{32'h3F800000, 32'h3F800000}, '{32'h7F800000, 32'h7F800000},
                     '{32'hFFC00000, 32'hFFC00000}, '{32'h00000001, 32'h00000001}};
`endif

        // 1: reset held with valid asserted
        rst = 1'b1;
        conv_valid = 1'b1;
        conv_data = mk_row(200);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_ready", 192'(conv_ready), 192'(0));
            check("rst_outputs", {data_out, fin, frame_done, busy, feature_idx, feature_row},
                  192'(0));
        end
        rst = 1'b0;
        conv_valid = 1'b0;
        step();
        check("ready_after_rst", 192'(conv_ready), 192'(1));
        check("busy_after_rst", 192'(busy), 192'(0));
        repeat (8) step();
        check("nothing_accepted_in_rst", 192'(sq.size()), 192'(0));

        // 2: single row latency and hold
        for (int l = 0; l < 6; l++) t2_row[191-32*l -: 32] = t2_lanes[l];
        conv_valid = 1'b1;
        conv_data = t2_row;
        check("t2_ready", 192'(conv_ready), 192'(1));
        step();
        conv_valid = 1'b0;
        check("t2_fin_T", 192'(fin), 192'(0));
        step();
        check("t2_fin_T1", 192'(fin), 192'(0));
        step();
        check("t2_fin_T2", 192'(fin), 192'(1));
        check("t2_data", data_out, t2_row);
        check("t2_tag", 192'({feature_idx, feature_row}), 192'(0));
        check("t2_frame_done", 192'(frame_done), 192'(0));
        held = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (fin !== 1'b0 || data_out !== t2_row || feature_idx !== 2'd0 || feature_row !== 3'd0) held = 1'b0;
        end
        check("t2_hold", 192'(held), 192'(1));

        // 3: 25 back-to-back rows, full frame then wrap
        do_reset();
        push_rows(25, 0, acc, stalled);
        wait_strobes(25, 400);
        for (int k = 0; k < 25 && k < sq.size(); k++) begin
            check($sformatf("t3_idx_%0d", k), 192'(sq[k].idx), 192'(tag_tab[k].idx));
            check($sformatf("t3_row_%0d", k), 192'(sq[k].row), 192'(tag_tab[k].row));
            check($sformatf("t3_fd_%0d", k), 192'(sq[k].fd), 192'(tag_tab[k].fd));
            check($sformatf("t3_data_%0d", k), sq[k].data, exp_q[k]);
            if (k > 0) check($sformatf("t3_gap_%0d", k), 192'(sq[k].cyc - sq[k-1].cyc), 192'(5));
        end
        repeat (12) step();
        check("t3_no_extra", 192'(sq.size()), 192'(25));

        // 4: back-pressure with six rows
        do_reset();
        push_rows(6, 50, acc, stalled);
        check("t4_stalled", 192'(stalled), 192'(1));
        check("t4_acc_before_stall", 192'(acc), 192'(5));
        wait_strobes(6, 200);
        for (int k = 0; k < 6 && k < sq.size(); k++) begin
            check($sformatf("t4_data_%0d", k), sq[k].data, exp_q[k]);
            check($sformatf("t4_tag_%0d", k), 192'({sq[k].idx, sq[k].row}), 192'({2'd0, 3'(k)}));
        end
        repeat (12) step();
        check("t4_no_dup", 192'(sq.size()), 192'(6));

        // 5: reset during GAP with three rows buffered
        do_reset();
        push_rows(4, 100, acc, stalled);
        check("t5_one_strobe", 192'(sq.size()), 192'(1));
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (20) step();
        check("t5_no_strobe_after_rst", 192'(sq.size()), 192'(1));
        check("t5_busy", 192'(busy), 192'(0));
        check("t5_ready", 192'(conv_ready), 192'(1));
        sq.delete();
        exp_q.delete();
        push_rows(1, 150, acc, stalled);
        wait_strobes(1, 50);
        if (sq.size() > 0) begin
            check("t5_tag_restart", 192'({sq[0].idx, sq[0].row}), 192'(0));
            check("t5_data", sq[0].data, exp_q[0]);
        end

        // 6: lane rectification table
        do_reset();
        for (int l = 0; l < 6; l++) begin
            relu_row_in[191-32*l -: 32] = lane_tab[l].lane_in;
            relu_exp[191-32*l -: 32]    = lane_tab[l].lane_exp;
        end
        conv_valid = 1'b1;
        conv_data = relu_row_in;
        step();
        conv_valid = 1'b0;
        wait_strobes(1, 50);
        if (sq.size() > 0) begin
            for (int l = 0; l < 6; l++) begin
                check($sformatf("t6_lane_%0d", l), 192'(sq[0].data[191-32*l -: 32]), 192'(relu_exp[191-32*l -: 32]));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
